map_writer: RTL and testbench

MAP_WRITER -- requirements
Module: map_writer

---
 rtl/map_writer.sv | 99 +++++++++
 tb/tb_map_writer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/map_writer.sv
// Map RAM writer: sweeps the whole 32x32x32 block map with layered terrain on
// request, and otherwise streams single-block edits into the RAM.
module map_writer #(
    parameter int GROUND_H = 8,
    parameter int STONE_ID = 1,
    parameter int DIRT_ID  = 2,
    parameter int GRASS_ID = 3,
    parameter int AIR_ID   = 0,
    parameter int NUM_IDS  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_init,
    input  logic        edit_valid,
    output logic        edit_ready,
    input  logic [4:0]  edit_x,
    input  logic [4:0]  edit_y,
    input  logic [4:0]  edit_z,
    input  logic [4:0]  edit_id,
    output logic [14:0] write_addr,
    output logic [4:0]  write_data,
    output logic        write_en,
    output logic        busy,
    output logic        init_done,
    output logic        edit_drop
);

    typedef enum logic {
        IDLE = 1'b0,
        INIT = 1'b1
    } state_t;

    state_t      state;
    logic [14:0] cnt;
    logic        edit_legal;

    // Layer id for height y; signed int arithmetic keeps small GROUND_H from wrapping.
    function automatic logic [4:0] init_id(input logic [4:0] y);
        int yi;
        yi = int'({27'd0, y});
        if (yi + 3 < GROUND_H)       return 5'(STONE_ID);
        else if (yi + 1 < GROUND_H)  return 5'(DIRT_ID);
        else if (yi + 1 == GROUND_H) return 5'(GRASS_ID);
        else                         return 5'(AIR_ID);
    endfunction

    assign edit_legal = ({27'd0, edit_id} < 32'(NUM_IDS));
    assign edit_ready = (state == IDLE);
    assign busy       = (state == INIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 15'd0;
            write_en   <= 1'b0;
            write_addr <= 15'd0;
            write_data <= 5'd0;
            edit_drop  <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            write_en  <= 1'b0;
            edit_drop <= 1'b0;
            case (state)
                IDLE: begin
                    // Sweep write n=0 issues on the same edge that sees start_init.
                    if (start_init) begin
                        state      <= INIT;
                        write_en   <= 1'b1;
                        write_addr <= 15'd0;
                        write_data <= init_id(5'd0);
                        cnt        <= 15'd1;
                    end else if (edit_valid) begin
                        if (edit_legal) begin
                            write_en   <= 1'b1;
                            write_addr <= {edit_y, edit_z, edit_x};
                            write_data <= edit_id;
                        end else begin
                            edit_drop  <= 1'b1;
                        end
                    end
                end
                INIT: begin
                    // write_addr holds the last sweep address; 0x7FFF means the sweep is done.
                    if (write_addr == 15'h7FFF) begin
                        state     <= IDLE;
                        init_done <= 1'b1;
                        cnt       <= 15'd0;
                    end else begin
                        write_en   <= 1'b1;
                        write_addr <= cnt;
                        write_data <= init_id(cnt[14:10]);
                        cnt        <= cnt + 15'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_map_writer.sv
// Bench for map_writer: expected RAM writes queued at stimulus time and popped
// as write_en strobes are observed.
module tb_map_writer;

    localparam int GH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_init;
    logic        edit_valid;
    logic        edit_ready;
    logic [4:0]  edit_x, edit_y, edit_z, edit_id;
    logic [14:0] write_addr;
    logic [4:0]  write_data;
    logic        write_en;
    logic        busy;
    logic        init_done;
    logic        edit_drop;

    logic [19:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          exp_drops = 0;
    int          got_drops = 0;

    map_writer #(.GROUND_H(GH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_init (start_init),
        .edit_valid (edit_valid),
        .edit_ready (edit_ready),
        .edit_x     (edit_x),
        .edit_y     (edit_y),
        .edit_z     (edit_z),
        .edit_id    (edit_id),
        .write_addr (write_addr),
        .write_data (write_data),
        .write_en   (write_en),
        .busy       (busy),
        .init_done  (init_done),
        .edit_drop  (edit_drop)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference terrain: stone below GH-3, dirt up to GH-2, grass at GH-1, air above.
    function automatic logic [4:0] model_init(input int y);
        if (y < GH - 3)       return 5'd1;
        else if (y < GH - 1)  return 5'd2;
        else if (y == GH - 1) return 5'd3;
        else                  return 5'd0;
    endfunction

    task automatic push_sweep(input int last);
        for (int n = 0; n <= last; n++)
            exp_q.push_back({15'(n), model_init(n >> 10)});
    endtask

    // Called just after a rising edge; presents one edit for exactly one edge.
    task automatic send_edit(input logic [4:0] x, input logic [4:0] y,
                             input logic [4:0] z, input logic [4:0] id);
        edit_valid = 1'b1;
        edit_x = x; edit_y = y; edit_z = z; edit_id = id;
        check("edit_ready_hi", 32'(edit_ready), 32'd1);
        if (id < 5'd16) exp_q.push_back({y, z, x, id});
        else            exp_drops++;
        @(posedge clk); #1;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (write_en) begin
                check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0)
                    check("wr_addr_data", 32'({write_addr, write_data}), 32'(exp_q.pop_front()));
            end
            if (edit_drop) got_drops++;
        end
    end

    initial begin
        logic found;
        rst = 1'b1; start_init = 1'b0; edit_valid = 1'b0;
        edit_x = '0; edit_y = '0; edit_z = '0; edit_id = '0;
        repeat (3) @(negedge clk);
        check("rst_outputs", 32'({write_en, write_addr, write_data, edit_drop, init_done, busy}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ctl", 32'({edit_ready, busy, write_en, init_done}), 32'b1000);

        // full sweep, with a stray start_init mid-sweep that must be ignored
        @(posedge clk); #1;
        push_sweep(32767);
        start_init = 1'b1;
        @(posedge clk); #1;
        start_init = 1'b0;
        for (int i = 0; i < 32768; i++) begin
            @(negedge clk);
            check("sweep_ctl", 32'({write_en, busy, edit_ready}), 32'b110);
            if (i == 0)      check("sweep_y0",  32'(write_data), 32'd1);
            if (i == 'h1400) check("sweep_y5",  32'(write_data), 32'd2);
            if (i == 'h1C00) check("sweep_y7",  32'(write_data), 32'd3);
            if (i == 'h2000) check("sweep_y8",  32'(write_data), 32'd0);
            if (i == 100) start_init = 1'b1;
            if (i == 101) start_init = 1'b0;
        end
        @(negedge clk);
        check("sweep_end", 32'({write_en, busy, edit_ready, init_done}), 32'b0011);

        // single edit, latency one cycle
        @(posedge clk); #1;
        send_edit(5'd3, 5'd9, 5'd17, 5'd5);
        edit_valid = 1'b0;
        @(negedge clk);
        check("edit_we",   32'(write_en),   32'd1);
        check("edit_addr", 32'(write_addr), 32'h2623);
        check("edit_data", 32'(write_data), 32'd5);

        // back-to-back edits
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++)
            send_edit(5'(k), 5'd2, 5'd3, 5'(k + 1));
        edit_valid = 1'b0;
        @(negedge clk);
        check("b2b_last", 32'({write_en, write_data}), 32'({1'b1, 5'd3}));

        // illegal id is dropped with a single-cycle pulse
        @(posedge clk); #1;
        send_edit(5'd1, 5'd1, 5'd1, 5'd20);
        edit_valid = 1'b0;
        @(negedge clk);
        check("drop_pulse", 32'({edit_drop, write_en}), 32'b10);
        @(negedge clk);
        check("drop_end",  32'(edit_drop),  32'd0);
        check("hold_data", 32'(write_data), 32'd3);

        // reset in the middle of a sweep
        @(posedge clk); #1;
        push_sweep(1000);
        start_init = 1'b1;
        @(posedge clk); #1;
        start_init = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            @(negedge clk); #1;
            if (write_en && write_addr == 15'd1000) found = 1'b1;
        end
        check("rst_reach_1000", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_abort", 32'({write_en, init_done, busy, edit_ready}), 32'b0001);
        check("rst_q_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;

        // start_init and edit together: sweep wins, held edit lands first IDLE cycle
        @(posedge clk); #1;
        push_sweep(32767);
        exp_q.push_back({5'd4, 5'd6, 5'd2, 5'd7});
        start_init = 1'b1;
        edit_valid = 1'b1;
        edit_x = 5'd2; edit_y = 5'd4; edit_z = 5'd6; edit_id = 5'd7;
        @(posedge clk); #1;
        start_init = 1'b0;
        for (int i = 0; i < 32768; i++) begin
            @(negedge clk);
            check("sweep2_ctl", 32'({write_en, busy, edit_ready}), 32'b110);
            if (i == 0) check("sweep2_addr0", 32'(write_addr), 32'd0);
        end
        @(negedge clk);
        check("sweep2_end", 32'({write_en, busy, edit_ready, init_done}), 32'b0011);
        @(posedge clk); #1;
        edit_valid = 1'b0;
        @(negedge clk);
        check("held_edit", 32'({write_en, write_addr, write_data}),
              32'({1'b1, 5'd4, 5'd6, 5'd2, 5'd7}));

        repeat (2) @(negedge clk);
        check("final_q_empty", 32'(exp_q.size()), 32'd0);
        check("drop_count", 32'(got_drops), 32'(exp_drops));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
